arbitro_rr4: RTL
================

# arbitro_rr4

Round-robin sequencer that sits around a 4:1 bus mux (`mux4a1BusParam`). It arbitrates among four requesting sources and drives the mux select `S`. It captures the mux output `Q` into a registered output stage, with a valid/ready handshake toward the downstream consumer. It turns the combinational mux into a fair, back-pressurable 4-channel data collector.

## Interface

Clocking: one clock, `clk`. Reset is `rst_n`, asynchronous and active-low.

Parameters:
- `ANCHO`, default 8: data width. Must match the `ANCHO` of the attached mux.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `REQ`  in  4  per-channel request, level; the source holds it until it sees its `ACK`
- `ACK`  out  4  one-hot, one-cycle pulse: that channel's data has been captured
- `S`  out  2  select driven to mux `S`; registered
- `Q_MUX`  in  ANCHO  mux output `Q`; combinational from `S`
- `DATO`  out  ANCHO  captured data
- `CANAL`  out  2  channel index of `DATO`
- `VALIDO`  out  1  `DATO`/`CANAL` valid
- `LISTO`  in  1  downstream ready

## Operation

- States: REPOSO, SELECCION, ENTREGA.
- Rotating pointer `ptr` (2 bits) holds the last granted channel. Search order is `ptr+1`, `ptr+2`, `ptr+3`, `ptr`, modulo 4 with wrap 3→0.
- Arbitration vector is `REQ & ~ACK`. A channel whose `ACK` is high this cycle is never re-granted in the same cycle.
- REPOSO:
  - If the arbitration vector is nonzero, load `S` with the winner and go to SELECCION.
  - Otherwise stay in REPOSO; `S` holds its value.
- SELECCION (exactly 1 cycle), at the edge:
  - `DATO` ← `Q_MUX`, `CANAL` ← `S`, `VALIDO` ← 1.
  - `ACK[S]` ← 1, `ptr` ← `S`.
  - Go to ENTREGA.
- ENTREGA:
  - `ACK` is cleared after its single cycle.
  - While `VALIDO && !LISTO`: `DATO`, `CANAL`, `VALIDO` and `S` all hold.
  - On `VALIDO && LISTO`:
    - `VALIDO` ← 0.
    - If the arbitration vector is nonzero, load `S` with the winner and go to SELECCION. Otherwise go to REPOSO.
- `S` changes only on a grant and is stable throughout SELECCION and ENTREGA.
- Requests that drop before being granted are simply not served; there is no request latching.
- `REQ = 0` forever keeps the block in REPOSO with all outputs at reset values (`S` keeps its last value).

## Timing

- Reset values (async, immediate on `rst_n` low):
  - state REPOSO, `ptr` = 3 (channel 0 has top priority after reset).
  - `S` = 0, `DATO` = 0, `CANAL` = 0, `VALIDO` = 0, `ACK` = 0.
- Reset mid-transfer: pending `DATO` is discarded and no `ACK` is issued. Sources keep `REQ` high and are re-served after reset release.
- Latency, with `REQ` sampled high in REPOSO at edge t:
  - `S` valid after edge t.
  - `VALIDO`, `DATO` and `ACK` valid after edge t+1 (2 cycles total).
- Throughput with `LISTO` = 1 and continuous requests: one transfer every 2 cycles.
- `Q_MUX` must be settled within the SELECCION cycle; the mux is combinational, so one cycle is sufficient.
- Handshake: a transfer completes on the edge where `VALIDO` and `LISTO` are both 1. `LISTO` may toggle freely. `VALIDO` never drops without a completed transfer, except on reset.
- Simultaneous events:
  - A handshake and new requests in the same ENTREGA cycle: the next grant is issued on that same edge.
  - The `ACK`'d channel still asserting `REQ` is masked for that cycle.

## Test plan

- **Single request:** after reset, `REQ` = 0100 with D2 = 0x1E, `LISTO` = 1 → after 1 cycle `S` = 2; after 2 cycles `DATO` = 0x1E, `CANAL` = 2, `VALIDO` = 1, `ACK` = 0100 for exactly one cycle.
- **Fairness:** `REQ` = 1111 held, `LISTO` = 1, D0..D3 = 10, 20, 30, 40 → `CANAL` sequence 0, 1, 2, 3, 0, ..., `DATO` 10, 20, 30, 40, 10; one `VALIDO` completion every 2 cycles.
- **Backpressure:** hold `LISTO` = 0 for 5 cycles during ENTREGA of channel 1 while D1 changes → `DATO`, `CANAL` = 1, `VALIDO` and `S` stable; a single `ACK` pulse; releases on the first `LISTO` = 1 edge.
- **Same-cycle masking:** only ch3 requests; it keeps `REQ` high one cycle past `ACK`, with `LISTO` = 1 → ch3 is not granted twice; the block returns to REPOSO.
- **Reset mid-ENTREGA:** assert `rst_n` = 0 while `VALIDO` = 1 → `VALIDO`, `ACK`, `DATO`, `S` go to 0 immediately. After release, ch0 wins against `REQ` = 1001.
- **Width:** `ANCHO` = 16, D2 = 0xBEEF, `REQ` = 0100 → `DATO` = 0xBEEF, `CANAL` = 2.

Source files
------------

// File: rtl/arbitro_rr4.sv
// arbitro_rr4: round-robin sequencer around a combinational 4:1 bus mux.
// Picks one of four requesting channels and drives the mux select S. It
// captures the mux output into a registered stage and hands it downstream
// with a valid/ready handshake.
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   REQ    - per-channel level request, held by the source until its ACK
//   ACK    - one-hot, one-cycle pulse: that channel's data was captured
//   S      - registered mux select
//   Q_MUX  - mux output (combinational from S)
//   DATO   - captured data
//   CANAL  - channel index of DATO
//   VALIDO - DATO/CANAL valid
//   LISTO  - downstream ready
module arbitro_rr4 #(
    parameter int ANCHO = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       REQ,
    output logic [3:0]       ACK,
    output logic [1:0]       S,
    input  logic [ANCHO-1:0] Q_MUX,
    output logic [ANCHO-1:0] DATO,
    output logic [1:0]       CANAL,
    output logic             VALIDO,
    input  logic             LISTO
);

    typedef enum logic [1:0] {REPOSO, SELECCION, ENTREGA} estado_t;

    estado_t    estado;
    logic [1:0] ptr;      // last granted channel
    logic [3:0] arb;
    logic       hay;
    logic [1:0] ganador;
    logic [1:0] idx;

    // A channel being ACK'd this cycle still has REQ high (the source only
    // drops it after seeing ACK), so mask it to avoid a double grant.
    assign arb = REQ & ~ACK;

    // Scan from the farthest offset down to the nearest so the closest
    // requester after ptr is the last (winning) assignment.
    always_comb begin
        hay     = 1'b0;
        ganador = ptr;
        idx     = '0;
        for (int i = 4; i >= 1; i--) begin
            idx = ptr + 2'(i);
            if (arb[idx]) begin
                hay     = 1'b1;
                ganador = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= REPOSO;
            ptr    <= 2'd3;   // channel 0 searched first after reset
            S      <= '0;
            DATO   <= '0;
            CANAL  <= '0;
            VALIDO <= 1'b0;
            ACK    <= '0;
        end else begin
            ACK <= '0;
            case (estado)
                REPOSO: begin
                    if (hay) begin
                        S      <= ganador;
                        estado <= SELECCION;
                    end
                end
                SELECCION: begin
                    // Q_MUX has had the whole cycle to settle on S.
                    DATO   <= Q_MUX;
                    CANAL  <= S;
                    VALIDO <= 1'b1;
                    ACK    <= 4'(1) << S;
                    ptr    <= S;
                    estado <= ENTREGA;
                end
                ENTREGA: begin
                    if (LISTO) begin
                        VALIDO <= 1'b0;
                        if (hay) begin
                            S      <= ganador;
                            estado <= SELECCION;
                        end else begin
                            estado <= REPOSO;
                        end
                    end
                end
                default: estado <= REPOSO;
            endcase
        end
    end

endmodule
